// File: rtl/module_calc_sequencer.sv
// Keypad calculator sequencer: builds two decimal operands from key codes,
// drives the request/done handshake with the shared adder and picks the display value.
module module_calc_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    input  logic        add_done,
    input  logic [10:0] add_sum,
    output logic        add_req,
    output logic [9:0]  add_a,
    output logic [9:0]  add_b,
    output logic [11:0] disp_bin,
    output logic        err,
    output logic [2:0]  phase
);

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_OP  = 3'd1,
        S_B   = 3'd2,
        S_REQ = 3'd3,
        S_RES = 3'd4
    } state_t;

    localparam int            TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    KEY_PLUS  = 4'hA;
    localparam logic [3:0]    KEY_EQUAL = 4'hB;
    localparam logic [3:0]    KEY_CLEAR = 4'hC;
    localparam logic [10:0]   MAX_OPND  = 11'd999;

    state_t        state;
    state_t        state_next;
    logic [9:0]    a_val;
    logic [9:0]    a_next;
    logic [9:0]    b_val;
    logic [9:0]    b_next;
    logic [1:0]    cnt_a;
    logic [1:0]    cnt_a_next;
    logic [1:0]    cnt_b;
    logic [1:0]    cnt_b_next;
    logic [10:0]   result;
    logic [10:0]   result_next;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_next;
    logic [9:0]    add_a_next;
    logic [9:0]    add_b_next;
    logic          add_req_next;
    logic          err_next;
    logic [11:0]   disp_next;

    logic          is_digit;
    logic          is_plus;
    logic          is_equal;
    logic          is_clear;
    logic          a_has_room;
    logic          b_has_room;
    logic [9:0]    a_appended;
    logic [9:0]    b_appended;
    logic [9:0]    key_value;

    // Multiply-by-ten via shifts keeps the append path free of a real multiplier.
    function automatic logic [9:0] append_digit(input logic [9:0] value,
                                                input logic [3:0] d);
        logic [9:0] times8;
        logic [9:0] times2;
        times8 = value << 3;
        times2 = value << 1;
        return times8 + times2 + {6'd0, d};
    endfunction

    always_comb begin
        is_digit   = key_valid && (key_code <= 4'd9);
        is_plus    = key_valid && (key_code == KEY_PLUS);
        is_equal   = key_valid && (key_code == KEY_EQUAL);
        is_clear   = key_valid && (key_code == KEY_CLEAR);
        key_value  = {6'd0, key_code};
        a_has_room = (cnt_a < 2'd3);
        b_has_room = (cnt_b < 2'd3);
        a_appended = append_digit(a_val, key_code);
        b_appended = append_digit(b_val, key_code);
    end

    always_comb begin
        state_next   = state;
        a_next       = a_val;
        b_next       = b_val;
        cnt_a_next   = cnt_a;
        cnt_b_next   = cnt_b;
        result_next  = result;
        tmo_next     = tmo_cnt;
        add_a_next   = add_a;
        add_b_next   = add_b;
        add_req_next = add_req;
        err_next     = err;

        // Clear outranks everything, including a done arriving on the same edge.
        if (is_clear) begin
            state_next   = S_A;
            a_next       = '0;
            b_next       = '0;
            cnt_a_next   = '0;
            cnt_b_next   = '0;
            result_next  = '0;
            tmo_next     = '0;
            add_a_next   = '0;
            add_b_next   = '0;
            add_req_next = 1'b0;
            err_next     = 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (is_digit) begin
                        if (a_has_room) begin
                            a_next     = a_appended;
                            cnt_a_next = cnt_a + 2'd1;
                        end
                    end else if (is_plus) begin
                        state_next = S_OP;
                    end
                end

                S_OP: begin
                    if (is_digit) begin
                        b_next     = key_value;
                        cnt_b_next = 2'd1;
                        state_next = S_B;
                    end else if (is_equal) begin
                        b_next       = '0;
                        cnt_b_next   = '0;
                        add_a_next   = a_val;
                        add_b_next   = '0;
                        add_req_next = 1'b1;
                        tmo_next     = '0;
                        state_next   = S_REQ;
                    end
                end

                S_B: begin
                    if (is_digit) begin
                        if (b_has_room) begin
                            b_next     = b_appended;
                            cnt_b_next = cnt_b + 2'd1;
                        end
                    end else if (is_equal) begin
                        add_a_next   = a_val;
                        add_b_next   = b_val;
                        add_req_next = 1'b1;
                        tmo_next     = '0;
                        state_next   = S_REQ;
                    end
                end

                S_REQ: begin
                    if (add_req && add_done) begin
                        result_next  = add_sum;
                        add_req_next = 1'b0;
                        state_next   = S_RES;
                    end else if (tmo_cnt == TMO_LAST) begin
                        result_next  = '0;
                        err_next     = 1'b1;
                        add_req_next = 1'b0;
                        state_next   = S_RES;
                    end else begin
                        tmo_next = tmo_cnt + 1'b1;
                    end
                end

                S_RES: begin
                    if (is_digit) begin
                        a_next     = key_value;
                        cnt_a_next = 2'd1;
                        b_next     = '0;
                        cnt_b_next = '0;
                        err_next   = 1'b0;
                        state_next = S_A;
                    end else if (is_plus && (result <= MAX_OPND) && !err) begin
                        // A full digit count stops appends onto a chained result.
                        a_next     = result[9:0];
                        cnt_a_next = 2'd3;
                        b_next     = '0;
                        cnt_b_next = '0;
                        state_next = S_OP;
                    end
                end

                default: begin
                    state_next = S_A;
                end
            endcase
        end
    end

    always_comb begin
        disp_next = '0;
        case (state_next)
            S_A, S_OP:  disp_next = {2'b00, a_next};
            S_B, S_REQ: disp_next = {2'b00, b_next};
            S_RES:      disp_next = err_next ? 12'd0 : {1'b0, result_next};
            default:    disp_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_A;
            a_val    <= '0;
            b_val    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            result   <= '0;
            tmo_cnt  <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_req  <= 1'b0;
            err      <= 1'b0;
            disp_bin <= '0;
        end else begin
            state    <= state_next;
            a_val    <= a_next;
            b_val    <= b_next;
            cnt_a    <= cnt_a_next;
            cnt_b    <= cnt_b_next;
            result   <= result_next;
            tmo_cnt  <= tmo_next;
            add_a    <= add_a_next;
            add_b    <= add_b_next;
            add_req  <= add_req_next;
            err      <= err_next;
            disp_bin <= disp_next;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_module_calc_sequencer.sv
// Scoreboard bench for module_calc_sequencer: a driver feeds keys and adder responses
// while pushing predictions from a calculator model; a monitor pops on every DUT event.
module tb_module_calc_sequencer;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_code = '0;
    logic        key_valid = 1'b0;
    logic        add_done = 1'b0;
    logic [10:0] add_sum = '0;
    logic        add_req;
    logic [9:0]  add_a;
    logic [9:0]  add_b;
    logic [11:0] disp_bin;
    logic        err;
    logic [2:0]  phase;

    int checks = 0;
    int failures = 0;

    module_calc_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .add_done  (add_done),
        .add_sum   (add_sum),
        .add_req   (add_req),
        .add_a     (add_a),
        .add_b     (add_b),
        .disp_bin  (disp_bin),
        .err       (err),
        .phase     (phase)
    );

    // The clock can be frozen low so asynchronous reset is seen without any edge.
    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        int phase;
        int disp;
        int err;
        int req;
        int a;
        int b;
        int chk_len;
        int req_len;
    } exp_t;

    exp_t exp_q[$];

    // Calculator model: state 0..4 = entering A, after '+', entering B, waiting, showing result.
    int m_st, m_a, m_b, m_na, m_nb, m_res, m_err, m_add_a, m_add_b, m_req;

    task automatic model_clear();
        m_st = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
        m_res = 0; m_err = 0; m_add_a = 0; m_add_b = 0; m_req = 0;
    endtask

    task automatic model_key(input int k, output bit entered);
        entered = 1'b0;
        if (k == 12) begin
            model_clear();
        end else if (k < 12) begin
            case (m_st)
                0: begin
                    if (k < 10) begin
                        if (m_na < 3) begin m_a = m_a * 10 + k; m_na++; end
                    end else if (k == 10) m_st = 1;
                end
                1: begin
                    if (k < 10) begin m_b = k; m_nb = 1; m_st = 2; end
                    else if (k == 11) begin
                        m_b = 0; m_nb = 0; m_add_a = m_a; m_add_b = 0; m_req = 1; m_st = 3;
                        entered = 1'b1;
                    end
                end
                2: begin
                    if (k < 10) begin
                        if (m_nb < 3) begin m_b = m_b * 10 + k; m_nb++; end
                    end else if (k == 11) begin
                        m_add_a = m_a; m_add_b = m_b; m_req = 1; m_st = 3;
                        entered = 1'b1;
                    end
                end
                4: begin
                    if (k < 10) begin
                        m_a = k; m_na = 1; m_b = 0; m_nb = 0; m_err = 0; m_st = 0;
                    end else if (k == 10 && m_res <= 999 && m_err == 0) begin
                        m_a = m_res; m_na = 3; m_b = 0; m_nb = 0; m_st = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t snapshot(input int chk, input int len);
        exp_t e;
        e.phase = m_st;
        if (m_st <= 1)      e.disp = m_a;
        else if (m_st <= 3) e.disp = m_b;
        else                e.disp = (m_err != 0) ? 0 : m_res;
        e.err = m_err;
        e.req = m_req;
        e.a = m_add_a;
        e.b = m_add_b;
        e.chk_len = chk;
        e.req_len = len;
        return e;
    endfunction

    task automatic cmp(input string name, input int ev, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("[TB] FAIL %s event=%0d got=%0d expected=%0d", name, ev, act, expv);
        end
    endtask

    int ev = 0;
    int req_len = 0;
    int kv;
    int rb;
    int fell;
    exp_t mon_e;

    task automatic check_output(input exp_t e);
        cmp("phase",    ev, int'(phase),    e.phase);
        cmp("disp_bin", ev, int'(disp_bin), e.disp);
        cmp("err",      ev, int'(err),      e.err);
        cmp("add_req",  ev, int'(add_req),  e.req);
        cmp("add_a",    ev, int'(add_a),    e.a);
        cmp("add_b",    ev, int'(add_b),    e.b);
        if (e.chk_len != 0) cmp("req_cycles", ev, req_len, e.req_len);
    endtask

    // Monitor: the DUT "presents" a result on a key edge or when add_req drops.
    initial begin
        forever begin
            @(posedge clk);
            kv = int'(key_valid);
            rb = int'(add_req);
            @(negedge clk);
            fell = (rb != 0 && add_req == 1'b0) ? 1 : 0;
            if (kv != 0 || fell != 0) begin
                ev++;
                if (exp_q.size() == 0) begin
                    cmp("unexpected_event", ev, 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output(mon_e);
                end
            end
            if (add_req) req_len++;
            else req_len = 0;
        end
    end

    task automatic async_reset_check(input string tag);
        clk_run = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        cmp({tag, "_add_req"},  0, int'(add_req),  0);
        cmp({tag, "_phase"},    0, int'(phase),    0);
        cmp({tag, "_disp_bin"}, 0, int'(disp_bin), 0);
        cmp({tag, "_err"},      0, int'(err),      0);
        cmp({tag, "_add_a"},    0, int'(add_a),    0);
        cmp({tag, "_add_b"},    0, int'(add_b),    0);
        model_clear();
        #2 rst_n = 1'b1;
        #2 clk_run = 1'b1;
        repeat (3) @(negedge clk);
        cmp({tag, "_phase_after"}, 0, int'(phase), 0);
        cmp({tag, "_disp_after"},  0, int'(disp_bin), 0);
    endtask

    // mode: 0 done after lat cycles, 1 never answer, 2 clear with done, 3 async reset.
    task automatic handle_adder(input int mode, input int lat, input int sum);
        int s;
        s = (sum < 0) ? (m_add_a + m_add_b) : sum;
        case (mode)
            0: begin
                repeat (lat - 1) @(negedge clk);
                add_done = 1'b1;
                add_sum = 11'(s);
                m_res = s; m_req = 0; m_st = 4;
                exp_q.push_back(snapshot(1, lat));
                @(negedge clk);
                add_done = 1'b0;
            end
            1: begin
                m_res = 0; m_err = 1; m_req = 0; m_st = 4;
                exp_q.push_back(snapshot(1, TMO));
                repeat (TMO) @(negedge clk);
            end
            2: begin
                repeat (lat - 1) @(negedge clk);
                add_done = 1'b1;
                add_sum = 11'(s);
                key_code = 4'hC;
                key_valid = 1'b1;
                model_clear();
                exp_q.push_back(snapshot(1, lat));
                @(negedge clk);
                add_done = 1'b0;
                key_valid = 1'b0;
                @(negedge clk);
                add_done = 1'b1;
                @(negedge clk);
                add_done = 1'b0;
            end
            default: begin
                repeat (lat - 1) @(negedge clk);
                async_reset_check("hs_reset");
            end
        endcase
    endtask

    task automatic apply_stimulus(input int k, input int mode, input int lat, input int sum);
        bit entered;
        @(negedge clk);
        key_code = 4'(k);
        key_valid = 1'b1;
        model_key(k, entered);
        exp_q.push_back(snapshot(0, 0));
        @(negedge clk);
        key_valid = 1'b0;
        if (entered) handle_adder(mode, lat, sum);
    endtask

    task automatic keys(input int seq[$], input int mode, input int lat, input int sum);
        foreach (seq[i]) apply_stimulus(seq[i], mode, lat, sum);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int r;
        int k;
        int rm;
        model_clear();
        #3;
        cmp("por_phase",    0, int'(phase),    0);
        cmp("por_disp_bin", 0, int'(disp_bin), 0);
        cmp("por_add_req",  0, int'(add_req),  0);
        cmp("por_err",      0, int'(err),      0);
        #3 rst_n = 1'b1;
        #2 clk_run = 1'b1;
        repeat (3) @(negedge clk);
        cmp("por_phase_after", 0, int'(phase), 0);

        keys('{1, 2, 3, 10, 4, 5, 11}, 0, 3, 168);
        keys('{10, 2, 11}, 0, 1, -1);
        keys('{12, 9, 9, 9, 9, 10, 11}, 0, 2, 999);
        keys('{12, 9, 9, 9, 10, 5, 0, 1, 11}, 0, 2, -1);
        keys('{10, 11, 13, 14, 15}, 0, 1, -1);
        keys('{12, 7, 10, 11}, 1, 1, -1);
        keys('{10, 5}, 0, 1, -1);
        keys('{10, 4, 11}, 2, 2, -1);
        keys('{6, 4, 2}, 0, 1, -1);
        async_reset_check("entry_reset");
        keys('{10, 1, 11}, 3, 2, -1);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      k = $urandom_range(0, 9);
            else if (r < 70) k = 10;
            else if (r < 87) k = 11;
            else if (r < 91) k = 12;
            else             k = $urandom_range(13, 15);
            rm = $urandom_range(0, 99);
            if (rm < 80)
                apply_stimulus(k, 0, $urandom_range(1, 5),
                               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : -1);
            else if (rm < 90)
                apply_stimulus(k, 1, 1, -1);
            else
                apply_stimulus(k, 2, $urandom_range(1, 4), -1);
        end

        repeat (4) @(negedge clk);
        cmp("queue_drained", 0, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/module_calc_sequencer.md
# module_calc_sequencer

Sequencing controller for the keypad adder datapath. It consumes decoded key codes (0–9 digits, A = '+', B = '=', C = clear) from the keypad scanner. It assembles two decimal operands of up to 3 digits and runs a request/done handshake with the shared adder. It also selects the 12-bit binary value fed to the binary-to-BCD converter and the 4-digit display controller, with an error flag for a non-responding adder.

## Interface
- TIMEOUT_CYCLES, 1024, cycles `add_req` may stay high without `add_done` before the error exit (≥2)
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- key_code  in  4  decoded key; valid only when `key_valid`=1
- key_valid  in  1  one-cycle pulse per accepted key press
- add_done  in  1  adder completion; sampled only while `add_req`=1
- add_sum  in  11  adder result; valid when `add_done`=1
- add_req  out  1  adder request, held until done/timeout/abort
- add_a  out  10  operand A; stable while `add_req`=1
- add_b  out  10  operand B; stable while `add_req`=1
- disp_bin  out  12  binary value for the BCD converter
- err  out  1  adder timeout flag
- phase  out  3  state encoding: 0=S_A, 1=S_OP, 2=S_B, 3=S_REQ, 4=S_RES

## Operation
- All outputs are registers. Reset values:
  - state S_A
  - A, B, result, digit counts, `add_a`, `add_b`, `disp_bin`: 0
  - `add_req`, `err`: 0
- Digit entry: if count <3, value ← value·10 + d (computed as (v<<3)+(v<<1)+d, 10 bits, max 999) and count++. A 4th digit is ignored.
- Keys D, E, F are ignored in every state. Key C (clear) in any state returns everything to the reset values and state S_A.
- S_A:
  - digit → append to A
  - '+' → S_OP (A=0 if no digits were entered)
  - '=' → ignored
- S_OP:
  - digit → B=d, countB=1, S_B
  - '=' → B=0, S_REQ
  - '+' → ignored
- S_B:
  - digit → append to B
  - '=' → S_REQ
  - '+' → ignored
- S_REQ:
  - On entry: `add_a`←A, `add_b`←B, `add_req`←1, timeout counter←0.
  - `add_done`=1 → result←`add_sum`, `add_req`←0, S_RES.
  - Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES−1 with no done: result←0, `err`←1, `add_req`←0, S_RES.
  - Digit, '+' and '=' keys are ignored.
- S_RES:
  - digit → A=d, countA=1, B=0, countB=0, `err`←0, S_A
  - '+' → if result ≤999 and `err`=0: A←result, countA=3 (no further digit append), B=0, S_OP. Otherwise ignored.
  - '=' → ignored
- `disp_bin` by state (zero-extended):
  - S_A, S_OP: A
  - S_B, S_REQ: B
  - S_RES: result (0 when `err`=1)

## Timing
- A key is processed on the clk edge where `key_valid`=1. New register values, including `disp_bin`, are visible after that same edge.
- `add_req` rises on the edge that samples '=' (from S_B or S_OP).
- `add_done` is sampled each edge while `add_req`=1. On that edge `add_req` falls and result is captured, so `disp_bin` shows the result on the following cycle. `add_done` while `add_req`=0 is ignored.
- Minimum handshake: `add_done` is high on the first edge after `add_req` rises, so `add_req` is high for exactly 1 cycle.
- `add_a` and `add_b` change only on S_REQ entry and on clear/reset.
- Simultaneous events:
  - `add_done` and the timeout edge together: done wins, `err`=0.
  - C key and `add_done` together: clear wins; done is dropped and the result is discarded.
- Asynchronous reset mid-handshake drops `add_req` immediately, with no wait for a clock edge.

## Test plan
- Reset: assert rst_n=0 mid-entry with no clock running → all outputs 0 immediately, phase=0. Release → state stays S_A.
- Keys 1,2,3,+,4,5,=; adder model answers 3 cycles after `add_req` with sum=168:
  - `disp_bin` sequence 1,12,123,123,4,45
  - `add_a`=123, `add_b`=45
  - `add_req` high exactly 3 cycles
  - `disp_bin`=168, phase=4
- Keys 9,9,9,9,+,= → A=999 (4th digit ignored), B=0, `add_b`=0. Model returns 999 → `disp_bin`=999.
- Chaining:
  - After result 168: keys +,2,= → `add_a`=168, `add_b`=2, `disp_bin`=170.
  - After result 1500: '+' is ignored and phase stays 4.
- Timeout with TIMEOUT_CYCLES=16 and no `add_done`:
  - After 16 cycles `add_req`=0, `err`=1, `disp_bin`=0.
  - Then key 5 → `err`=0, `disp_bin`=5, phase=0.
- Key C on the same edge as `add_done`=1 in S_REQ → all registers 0, phase=0, `add_sum` not captured. A later `add_done` pulse has no effect.
